// File: rtl/board_pkg.sv
// board_pkg: shared board-level switch types and debounce FSM encoding
package board_pkg;
  localparam int SWITCH_WIDTH = 4;
  typedef logic [SWITCH_WIDTH-1:0] switch_t;
  typedef enum logic {DB_STABLE = 1'b0, DB_PENDING = 1'b1} db_state_t;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchronizer plus tick-sampled debounce FSM for one switch bit
module debounce_bit
  import board_pkg::*;
#(
  parameter int STABLE_COUNT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic valid,
  input  logic raw,
  output logic state,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(STABLE_COUNT + 1);
  logic sync1_q, sync1_d, sync2_q, sync2_d;
  logic state_q, state_d, rise_q, rise_d, fall_q, fall_d;
  db_state_t fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc, next_cnt;
  logic differ, accept, settle;
  assign cnt_inc = cnt_q + 1'b1;
  // A differing sample starts a run at 1 from STABLE or extends it in PENDING; the run reaching
  // STABLE_COUNT accepts the new level, a matching sample abandons the run.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    differ   = sync2_q != state_q;
    next_cnt = (fsm_q == DB_STABLE) ? CW'(1) : cnt_inc;
    accept   = tick && differ && (next_cnt == CW'(STABLE_COUNT));
    settle   = accept || !differ;
    fsm_d    = !tick ? fsm_q : settle ? DB_STABLE : DB_PENDING;
    cnt_d    = !tick ? cnt_q : settle ? '0 : next_cnt;
    state_d  = accept ? sync2_q : state_q;
    rise_d   = accept && valid && sync2_q;
    fall_d   = accept && valid && !sync2_q;
  end
  // Synchronizer, FSM and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fsm_q   <= DB_STABLE;
      cnt_q   <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign state = state_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes and debounces slide switches into clean levels and edge pulses
module switch_debouncer
  import board_pkg::*;
#(
  parameter int WIDTH        = SWITCH_WIDTH,
  parameter int SAMPLE_RATIO = 100_000,
  parameter int STABLE_COUNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch_state,
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall,
  output logic             switch_valid
);
  localparam int TW = (SAMPLE_RATIO > 1) ? $clog2(SAMPLE_RATIO) : 1;
  localparam int VW = $clog2(STABLE_COUNT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic valid_q, valid_d, tick, vsat;
  // Shared sample tick and the saturating tick count that qualifies the edge pulses
  always_comb begin
    tick    = tcnt_q == TW'(SAMPLE_RATIO - 1);
    tcnt_d  = tick ? '0 : tcnt_q + 1'b1;
    vsat    = vcnt_q == VW'(STABLE_COUNT);
    vcnt_d  = (tick && !vsat) ? vcnt_q + 1'b1 : vcnt_q;
    valid_d = vsat;
  end
  // Tick and valid registers
  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt_q  <= '0;
      vcnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      vcnt_q  <= vcnt_d;
      valid_q <= valid_d;
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.STABLE_COUNT(STABLE_COUNT)) u_bit (
      .clock(clock),
      .reset(reset),
      .tick (tick),
      .valid(valid_q),
      .raw  (switch_raw[i]),
      .state(switch_state[i]),
      .rise (switch_rise[i]),
      .fall (switch_fall[i])
    );
  end
  assign switch_valid = valid_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: randomized and directed checks of two debouncer builds against a run-length model
module tb_switch_debouncer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] raw_a = '0, raw_b = '0;
  logic [3:0] st_a, ri_a, fa_a, st_b, ri_b, fa_b;
  logic va_a, va_b;
  int total = 0, passed = 0, cyc = 0;
  logic [3:0] m_p1[2], m_p2[2], m_st[2], m_ri[2], m_fa[2];
  logic m_v[2];
  int m_run[2][4];
  int m_n[2];
  always #5 clk = ~clk;
  switch_debouncer #(.WIDTH(4), .SAMPLE_RATIO(2), .STABLE_COUNT(3)) dut_a (
    .clock(clk), .reset(rst), .switch_raw(raw_a), .switch_state(st_a),
    .switch_rise(ri_a), .switch_fall(fa_a), .switch_valid(va_a)
  );
  switch_debouncer #(.WIDTH(4), .SAMPLE_RATIO(1), .STABLE_COUNT(1)) dut_b (
    .clock(clk), .reset(rst), .switch_raw(raw_b), .switch_state(st_b),
    .switch_rise(ri_b), .switch_fall(fa_b), .switch_valid(va_b)
  );
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s cycle %0d got %b expected %b", tag, cyc, got, exp);
  endtask
  // Model: raw reaches the sampler two edges late; ticks fall on every r-th edge after reset;
  // a level is adopted after sc consecutive tick samples disagreeing with it.
  task automatic model_edge(input int d, input int r, input int sc, input logic [3:0] raw, input logic rs);
    logic [3:0] s;
    logic was_valid;
    if (rs) begin
      m_p1[d] = '0; m_p2[d] = '0; m_st[d] = '0; m_ri[d] = '0; m_fa[d] = '0;
      m_v[d] = 1'b0; m_n[d] = 0;
      for (int b = 0; b < 4; b++) m_run[d][b] = 0;
      return;
    end
    m_n[d]++;
    s = m_p2[d];
    m_p2[d] = m_p1[d];
    m_p1[d] = raw;
    was_valid = m_v[d];
    m_ri[d] = '0;
    m_fa[d] = '0;
    if (m_n[d] % r == 0)
      for (int b = 0; b < 4; b++) begin
        if (s[b] == m_st[d][b]) m_run[d][b] = 0;
        else begin
          m_run[d][b]++;
          if (m_run[d][b] == sc) begin
            m_run[d][b] = 0;
            m_st[d][b] = s[b];
            if (was_valid && s[b]) m_ri[d][b] = 1'b1;
            if (was_valid && !s[b]) m_fa[d][b] = 1'b1;
          end
        end
      end
    m_v[d] = ((m_n[d] - 1) / r) >= sc;
  endtask
  task automatic step(input logic [3:0] ra, input logic [3:0] rb, input logic rs);
    raw_a = ra;
    raw_b = rb;
    rst = rs;
    @(posedge clk);
    cyc++;
    model_edge(0, 2, 3, ra, rs);
    model_edge(1, 1, 1, rb, rs);
    #1;
    check("state_a", st_a, m_st[0]);
    check("rise_a", ri_a, m_ri[0]);
    check("fall_a", fa_a, m_fa[0]);
    check("valid_a", {3'b0, va_a}, {3'b0, m_v[0]});
    check("state_b", st_b, m_st[1]);
    check("rise_b", ri_b, m_ri[1]);
    check("fall_b", fa_b, m_fa[1]);
    check("valid_b", {3'b0, va_b}, {3'b0, m_v[1]});
  endtask
  initial begin
    int rise_seen;
    repeat (2) step(4'b0000, 4'b0000, 1'b1);
    check("reset_state", st_a, 4'b0000);
    check("reset_valid", {3'b0, va_a}, 4'b0000);
    repeat (7) step(4'b0000, 4'b0000, 1'b0);
    check("valid_by_7", {3'b0, va_a}, 4'b0001);
    rise_seen = 0;
    repeat (10) begin
      step(4'b1000, 4'b1000, 1'b0);
      rise_seen += (ri_a == 4'b1000) ? 1 : 0;
      check("step_no_fall", fa_a, 4'b0000);
    end
    check("step_state", st_a, 4'b1000);
    check("step_rise_once", 4'(rise_seen), 4'd1);
    repeat (3) step(4'b1001, 4'b1000, 1'b0);
    repeat (10) begin
      step(4'b1000, 4'b1000, 1'b0);
      check("glitch_no_rise", ri_a, 4'b0000);
    end
    check("glitch_state", st_a, 4'b1000);
    repeat (10) step(4'b0101, 4'b0101, 1'b0);
    check("multi_state", st_a, 4'b0101);
    repeat (4) step(4'b1111, 4'b1111, 1'b0);
    step(4'b1111, 4'b1111, 1'b1);
    check("midreset_state", st_a, 4'b0000);
    check("midreset_valid", {3'b0, va_a}, 4'b0000);
    repeat (12) begin
      step(4'b1111, 4'b1111, 1'b0);
      if (!va_a) check("no_rise_invalid", ri_a, 4'b0000);
    end
    check("midreset_accept", st_a, 4'b1111);
    step(4'b0000, 4'b0110, 1'b0);
    step(4'b0000, 4'b0110, 1'b0);
    step(4'b0000, 4'b0110, 1'b0);
    check("fast_follow3", st_b, 4'b0110);
    check("fast_fall", fa_b, 4'b1001);
    step(4'b0000, 4'b0110, 1'b0);
    check("fast_pulse1", fa_b, 4'b0000);
    for (int k = 0; k < 60; k++) begin
      logic [3:0] va, vb;
      int h;
      va = 4'($urandom);
      vb = 4'($urandom);
      h = $urandom_range(1, 9);
      if ($urandom_range(0, 19) == 0) step(va, vb, 1'b1);
      for (int j = 0; j < h; j++) step(va, vb, 1'b0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
